// File: rtl/data_mux_rr_arbiter_if.sv
// Handshake bundle between the five requesters/consumer and the round-robin
// arbiter that drives the one-hot data mux select lines.
interface data_mux_rr_arbiter_if #(
  parameter int BURST_W = 3
);
  logic [4:0]         req;
  logic [BURST_W-1:0] burst_len;
  logic               beat_ok;
  logic [4:0]         sel;
  logic               gnt_valid;
  logic [2:0]         gnt_id;
  logic [BURST_W-1:0] beat_cnt;
  logic               done;
  logic               abort;

  // Requester/consumer side.
  modport master (
    output req, burst_len, beat_ok,
    input  sel, gnt_valid, gnt_id, beat_cnt, done, abort
  );

  // Arbiter side.
  modport slave (
    input  req, burst_len, beat_ok,
    output sel, gnt_valid, gnt_id, beat_cnt, done, abort
  );
endinterface

// File: rtl/data_mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 5-input one-hot data mux. Grants one
// requester at a time for a burst of beats, then forces a one-cycle all-zero
// select gap so two sources never drive the shared output together.
module data_mux_rr_arbiter #(
  parameter int N_REQ   = 5,
  parameter int BURST_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mux_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   sel_q, sel_d;
  logic               gnt_valid_q;
  logic [2:0]         gnt_id_q, gnt_id_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [2:0]         offset;
  logic [3:0]         winner_sum;
  logic [2:0]         winner;
  logic               found;
  logic [BURST_W-1:0] eff_len;

  // Rotating-priority pick: rotate req so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to a requester index mod 5.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    req_dbl = {bus.req, bus.req} >> rr_ptr_q;
    found   = |bus.req;
    offset  = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_dbl[i]) offset = 3'(i);
    end
    winner_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    winner     = (winner_sum >= 4'd5) ? 3'(winner_sum - 4'd5) : winner_sum[2:0];
    eff_len    = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
    cnt_inc    = cnt_q + BURST_W'(1);
  end

  // Next-state and next-output logic of the IDLE/GRANT/GAP sequencer.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d    = N_REQ'(1) << winner;
          gnt_id_d = winner;
          len_d    = eff_len;
          cnt_d    = '0;
          rr_ptr_d = (winner == 3'd4) ? 3'd0 : winner + 3'd1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (bus.beat_ok) begin
          // An accepted beat counts even if req drops in the same cycle.
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            sel_d   = '0;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!bus.req[gnt_id_q]) begin
          abort_d = 1'b1;
          sel_d   = '0;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        // gnt_id stays visible during the gap and clears on entering IDLE.
        sel_d    = '0;
        cnt_d    = '0;
        gnt_id_d = 3'd0;
        state_d  = IDLE;
      end
      default: begin
        sel_d    = '0;
        cnt_d    = '0;
        gnt_id_d = 3'd0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous active-low reset, and non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 3'd0;
      rr_ptr_q    <= 3'd0;
      len_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_valid_q <= |sel_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_data_mux_rr_arbiter.sv
// Self-checking bench for data_mux_rr_arbiter. Expected grant ids are queued
// when stimulus is applied and popped when a new grant appears on the bus.
module tb_data_mux_rr_arbiter;
  localparam int BURST_W = 3;

  logic clk = 1'b0;
  logic rst_n;

  data_mux_rr_arbiter_if #(.BURST_W(BURST_W)) bus ();

  data_mux_rr_arbiter #(.N_REQ(5), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int onehot_err = 0;
  int exp_q[$];

  // sel must be one-hot or zero at every sample point.
  always @(negedge clk) begin
    if (!$onehot0(bus.sel)) begin
      onehot_err++;
      $display("FAIL onehot_sel: got %b, need one-hot or zero", bus.sel);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    bus.beat_ok = 1'b0;
    bus.burst_len = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(input string tag);
    int k = 0;
    while (bus.gnt_valid !== 1'b1) begin
      tick();
      k++;
      if (k > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: no grant after %0d cycles, need a grant", tag, k);
        return;
      end
    end
  endtask

  // Watches grants until n_grants bursts complete with done; checks ids
  // against the scoreboard, beat count, gap state and optional spacing.
  task automatic collect(input int n_grants, input int beats, input int spacing,
                         input string tag);
    int seen = 0;
    int last = -1;
    int run = 0;
    int cyc = 0;
    int id = 0;
    logic [4:0] exp_sel;
    logic prev = bus.gnt_valid;
    while (seen < n_grants) begin
      tick();
      cyc++;
      if (cyc > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: got %0d bursts, need %0d", tag, seen, n_grants);
        return;
      end
      if (bus.gnt_valid && !prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s_unexpected: got grant %0d, need none", tag, bus.gnt_id);
        end else begin
          id = exp_q.pop_front();
          exp_sel = 5'b00001 << id;
          if (bus.gnt_id !== 3'(id)) begin
            n_bad++;
            $display("FAIL %s_gnt_id: got %0d, need %0d", tag, bus.gnt_id, id);
          end
          n_cmp++;
          if (bus.sel !== exp_sel) begin
            n_bad++;
            $display("FAIL %s_sel: got %b, need %b", tag, bus.sel, exp_sel);
          end
        end
        if (spacing > 0 && last >= 0) begin
          n_cmp++;
          if (cyc - last != spacing) begin
            n_bad++;
            $display("FAIL %s_spacing: got %0d, need %0d", tag, cyc - last, spacing);
          end
        end
        last = cyc;
        run = 0;
      end
      if (bus.gnt_valid) run++;
      if (bus.done) begin
        seen++;
        n_cmp++;
        if (run != beats) begin
          n_bad++;
          $display("FAIL %s_beats: got %0d, need %0d", tag, run, beats);
        end
        n_cmp++;
        if (bus.sel !== 5'b0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 3'(id) ||
            bus.beat_cnt !== '0 || bus.abort !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_gap: got sel=%b v=%b id=%0d cnt=%0d abort=%b, need 0/0/%0d/0/0",
                   tag, bus.sel, bus.gnt_valid, bus.gnt_id, bus.beat_cnt, bus.abort, id);
        end
      end
      prev = bus.gnt_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.burst_len = '0;
    bus.beat_ok = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.sel, bus.gnt_valid, bus.gnt_id, bus.beat_cnt, bus.done, bus.abort} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got sel=%b v=%b id=%0d cnt=%0d done=%b abort=%b, need all 0",
               bus.sel, bus.gnt_valid, bus.gnt_id, bus.beat_cnt, bus.done, bus.abort);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.sel !== 5'b0 || bus.gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got sel=%b v=%b, need 0/0", bus.sel, bus.gnt_valid);
    end
  endtask

  task automatic test_single_burst();
    bus.req = 5'b00100;
    bus.burst_len = 3'd3;
    bus.beat_ok = 1'b1;
    exp_q.push_back(2);
    collect(1, 3, 0, "single");
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt_id !== 3'd0 || bus.done !== 1'b0 || bus.sel !== 5'b0) begin
      n_bad++;
      $display("FAIL single_idle: got id=%0d done=%b sel=%b, need 0/0/0",
               bus.gnt_id, bus.done, bus.sel);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 5'b11111;
    bus.burst_len = 3'd1;
    bus.beat_ok = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(0);
    collect(6, 1, 3, "rr");
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] reqs [4] = '{5'b01000, 5'b10000, 5'b10001, 5'b10001};
    int exps [4] = '{3, 4, 0, 4};
    for (int s = 0; s < 4; s++) begin
      bus.req = reqs[s];
      bus.burst_len = 3'd1;
      bus.beat_ok = 1'b1;
      exp_q.push_back(exps[s]);
      collect(1, 1, 0, "wrap");
    end
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    bus.req = 5'b00010;
    bus.burst_len = 3'd5;
    bus.beat_ok = 1'b1;
    wait_grant("abort");
    n_cmp++;
    if (bus.gnt_id !== 3'd1) begin
      n_bad++;
      $display("FAIL abort_gnt_id: got %0d, need 1", bus.gnt_id);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.beat_cnt !== 3'd2 || bus.sel !== 5'b00010) begin
      n_bad++;
      $display("FAIL abort_pre: got cnt=%0d sel=%b, need 2/00010", bus.beat_cnt, bus.sel);
    end
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
    n_cmp++;
    if (bus.abort !== 1'b1 || bus.done !== 1'b0 || bus.sel !== 5'b0 || bus.gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_pulse: got abort=%b done=%b sel=%b v=%b, need 1/0/0/0",
               bus.abort, bus.done, bus.sel, bus.gnt_valid);
    end
    tick();
    n_cmp++;
    if (bus.abort !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after: got abort=%b done=%b, need 0/0", bus.abort, bus.done);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.req = 5'b01000;
    bus.burst_len = 3'd7;
    bus.beat_ok = 1'b1;
    wait_grant("midrst");
    tick();
    tick();
    n_cmp++;
    if (bus.beat_cnt !== 3'd2 || bus.sel !== 5'b01000) begin
      n_bad++;
      $display("FAIL midrst_pre: got cnt=%0d sel=%b, need 2/01000", bus.beat_cnt, bus.sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.sel, bus.gnt_valid, bus.gnt_id, bus.beat_cnt, bus.done, bus.abort} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async: got sel=%b v=%b id=%0d cnt=%0d, need all 0",
               bus.sel, bus.gnt_valid, bus.gnt_id, bus.beat_cnt);
    end
    tick();
    rst_n = 1'b1;
    wait_grant("midrst_regrant");
    n_cmp++;
    if (bus.gnt_id !== 3'd3 || bus.beat_cnt !== 3'd0 || bus.sel !== 5'b01000) begin
      n_bad++;
      $display("FAIL midrst_regrant: got id=%0d cnt=%0d sel=%b, need 3/0/01000",
               bus.gnt_id, bus.beat_cnt, bus.sel);
    end
    tick();
    n_cmp++;
    if (bus.beat_cnt !== 3'd1) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d, need 1", bus.beat_cnt);
    end
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ptr_after_reset();
    do_reset();
    bus.req = 5'b10001;
    bus.burst_len = 3'd1;
    bus.beat_ok = 1'b1;
    exp_q.push_back(0);
    collect(1, 1, 0, "ptr_rst");
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
  endtask

  task automatic test_len_zero();
    bus.req = 5'b00001;
    bus.burst_len = 3'd0;
    bus.beat_ok = 1'b1;
    exp_q.push_back(0);
    collect(1, 1, 0, "len0");
    bus.req = '0;
    bus.beat_ok = 1'b0;
    tick();
  endtask

  task automatic test_last_beat_drop();
    bus.req = 5'b00100;
    bus.burst_len = 3'd2;
    bus.beat_ok = 1'b1;
    wait_grant("lastdrop");
    tick();
    bus.req = '0;
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.abort !== 1'b0) begin
      n_bad++;
      $display("FAIL lastdrop_pulse: got done=%b abort=%b, need 1/0", bus.done, bus.abort);
    end
    bus.beat_ok = 1'b0;
    tick();
    n_cmp++;
    if (bus.abort !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL lastdrop_after: got done=%b abort=%b, need 0/0", bus.done, bus.abort);
    end
  endtask

  task automatic test_onehot();
    n_cmp++;
    if (onehot_err !== 0) begin
      n_bad++;
      $display("FAIL onehot_total: got %0d violations, need 0", onehot_err);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: got %0d pending grants, need 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wrap();
    test_abort();
    test_reset_mid_burst();
    test_ptr_after_reset();
    test_len_zero();
    test_last_beat_drop();
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
